ice40_iserdes_align: RTL

- 1:4 input deserializer, the receive counterpart of the team's 4:1 output serializer. Runs entirely in the bit-rate clock domain.
- Shifts a serial sample stream MSB-first into 4-bit words and emits a one-cycle word strobe every 4 clocks.
- Provides manual bit-slip plus an automatic training-pattern word aligner.
- Sits between the iCE40 input pad register and 1x-rate consumers of the link.

---
 rtl/ice40_iserdes_align.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ice40_iserdes_align.sv
// 1:4 MSB-first deserializer with bitslip and a training-pattern word aligner; ICE40_ISERDES_INREG_EN adds a pad input register.
// Latency: first q_stb 4 clks after reset release (5 with the input register); no backpressure, consumers must take every q_stb.
module ice40_iserdes_align #(
  parameter logic [3:0]  TRAIN_PAT = 4'b0011,
  parameter int unsigned MATCH_CNT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d,
  input  logic       bitslip,
  input  logic       align_req,
  output logic [3:0] q,
  output logic       q_stb,
  output logic       aligned,
  output logic       align_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    CHECK  = 3'd2,
    LOCKED = 3'd3,
    FAIL   = 3'd4
  } state_t;

  state_t     state_q;
  logic [3:0] sr_q;
  logic [1:0] ph_q;
  logic [3:0] q_q;
  logic       q_stb_q;
  logic [1:0] slip_cnt_q;
  logic [3:0] match_cnt_q;
  logic       settle_q;
  logic       slip_req_q;
  logic       aligned_q;
  logic       align_err_q;

  logic       din;
  logic       run;
  logic       slip;
  logic       capture;
  logic [3:0] word_d;
  logic [4:0] match_nxt;

`ifdef ICE40_ISERDES_INREG_EN
  logic d_q;
  logic prime_q;

  // Phase counting starts one clk late so the first word still begins with b0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= 1'b0;
      prime_q <= 1'b0;
    end else begin
      d_q     <= d;
      prime_q <= 1'b1;
    end
  end

  assign din = d_q;
  assign run = prime_q;
`else
  assign din = d;
  assign run = 1'b1;
`endif

  assign slip      = bitslip | slip_req_q;
  assign capture   = run & ~slip & (ph_q == 2'd3);
  assign word_d    = {sr_q[2:0], din};
  assign match_nxt = {1'b0, match_cnt_q} + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= 4'd0;
      ph_q    <= 2'd0;
      q_q     <= 4'd0;
      q_stb_q <= 1'b0;
    end else begin
      sr_q    <= word_d;
      q_stb_q <= capture;
      if (run && !slip) begin
        ph_q <= ph_q + 2'd1;
      end
      if (capture) begin
        q_q <= word_d;
      end
    end
  end

  // A slip request is a registered single-cycle pulse; the next word after it is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slip_cnt_q  <= 2'd0;
      match_cnt_q <= 4'd0;
      settle_q    <= 1'b0;
      slip_req_q  <= 1'b0;
      aligned_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      slip_req_q <= 1'b0;
      if (align_req) begin
        state_q     <= SEARCH;
        slip_cnt_q  <= 2'd0;
        match_cnt_q <= 4'd0;
        settle_q    <= 1'b0;
        aligned_q   <= 1'b0;
        align_err_q <= 1'b0;
      end else if (q_stb_q) begin
        case (state_q)
          SEARCH, CHECK: begin
            if (settle_q) begin
              settle_q <= 1'b0;
            end else if (q_q == TRAIN_PAT) begin
              match_cnt_q <= match_nxt[3:0];
              if (match_nxt >= 5'(MATCH_CNT)) begin
                state_q   <= LOCKED;
                aligned_q <= 1'b1;
              end else begin
                state_q <= CHECK;
              end
            end else if (slip_cnt_q != 2'd3) begin
              state_q     <= SEARCH;
              slip_req_q  <= 1'b1;
              slip_cnt_q  <= slip_cnt_q + 2'd1;
              settle_q    <= 1'b1;
              match_cnt_q <= 4'd0;
            end else begin
              state_q     <= FAIL;
              match_cnt_q <= 4'd0;
              align_err_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign q         = q_q;
  assign q_stb     = q_stb_q;
  assign aligned   = aligned_q;
  assign align_err = align_err_q;

endmodule
